bit_scan_serializer: RTL and testbench
======================================

BIT_SCAN_SERIALIZER -- requirements
Module: bit_scan_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the input mask (legal range 2..64).
REQ-002 SHALL have derived localparam IDXW = $clog2(WIDTH), index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_mask.
REQ-006 SHALL have port in_ready  output  1  block accepts in_mask this cycle.
REQ-007 SHALL have port in_mask  input  WIDTH  bitmask to serialize.
REQ-008 SHALL have port out_valid  output  1  out_idx/out_seq/out_last are valid.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the current output.
REQ-010 SHALL have port out_idx  output  IDXW  position of the selected set bit.
REQ-011 SHALL have port out_seq  output  IDXW+1  ordinal of this output within the current mask, from 0.
REQ-012 SHALL have port out_last  output  1  this is the final set bit of the current mask.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, SCAN.
REQ-014 IDLE: in_ready=1 and out_valid=0.
REQ-015 IDLE, in_valid=1 with nonzero in_mask: load working register and clear the seq counter; next state SCAN.
REQ-016 IDLE, in_valid=1 with in_mask==0: accept and discard the mask, produce no output, stay in IDLE.
REQ-017 SCAN: out_valid=1; out_idx = lowest set bit of the working register; out_last=1 iff exactly one bit is set; out_seq = seq counter.
REQ-018 Index selection SHALL be a loop-based function that returns early on the first set bit.
REQ-019 SCAN, out_valid && out_ready && !out_last: clear bit out_idx in the working register and increment seq.
REQ-020 SCAN, out_valid && out_ready && out_last: in_ready=1 in the same cycle (combinational path from out_ready).
- Without a new mask: next state IDLE.
- New nonzero mask accepted: reload the working register, seq=0, stay in SCAN (no bubble).
- New zero mask accepted: discard it, next state IDLE.
REQ-021 SCAN otherwise: in_ready=0.
REQ-022 Latency: a mask accepted in cycle N SHALL give its first out_valid in cycle N+1.
REQ-023 Under backpressure (out_ready=0), out_idx, out_seq and out_last SHALL hold stable.
REQ-024 An all-ones mask SHALL produce exactly WIDTH outputs, out_seq 0..WIDTH-1; the counter SHALL never wrap.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, working register 0 and seq 0, including mid-scan; the remaining bits of an in-progress mask are discarded.
REQ-026 After reset, outputs SHALL be out_valid=0, in_ready=1, out_idx=0, out_seq=0, out_last=0.
REQ-027 While rst=1, an in_valid handshake SHALL have no effect.

Configuration
REQ-028 Macro BIT_SCAN_MSB_FIRST_EN defined: selection SHALL pick the highest set bit instead, emitting indices in descending order.
REQ-029 Macro BIT_SCAN_MSB_FIRST_EN absent: selection SHALL use ascending (LSB-first) order.
REQ-030 All other behaviour SHALL be identical in both builds.

Structure
REQ-031 Package bit_scan_pkg SHALL hold the FSM state enum and the pick-first-set-bit function (early return from the loop; direction selected by the macro).
REQ-032 No sub-module; single module plus package.

Verification (WIDTH=8)
REQ-033 Basic order: mask 8'b1010_0100, out_ready=1 -> out_idx 2,5,7; out_seq 0,1,2; out_last only with idx 7.
REQ-034 Zero mask: mask 8'h00 accepted -> out_valid stays 0; in_ready stays 1.
REQ-035 Backpressure: mask 8'h14, out_ready=0 for 3 cycles -> idx=2, seq=0 stable for 3 cycles; out_ready=1 -> idx 2, then 4 (last).
REQ-036 Back-to-back: mask 8'h80 then 8'h01 offered continuously -> idx 7 (last) then idx 0 (last) in consecutive cycles, no bubble.
REQ-037 Mid-scan reset: mask 8'hFF, rst after 3 outputs -> next cycle out_valid=0, in_ready=1; new mask 8'h02 -> idx 1, seq 0.
REQ-038 MSB-first build: with BIT_SCAN_MSB_FIRST_EN defined, mask 8'b1010_0100 -> idx 7,5,2; out_last with idx 2.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// Shared types and set-bit picker for bit_scan_serializer.
// BIT_SCAN_MSB_FIRST_EN selects highest-set-bit-first order.
package bit_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int MAXW = 64;

    function automatic int pick_first(
        input logic [MAXW-1:0] m,
        input int              w
    );
`ifdef BIT_SCAN_MSB_FIRST_EN
        for (int i = MAXW - 1; i >= 0; i--) begin
            if (i < w && m[i]) return i;
        end
`else
        for (int i = 0; i < MAXW; i++) begin
            if (i < w && m[i]) return i;
        end
`endif
        return 0;
    endfunction

endpackage

// File: rtl/bit_scan_serializer.sv
// Emits the indices of set bits of each accepted mask, one per handshake.
// BIT_SCAN_MSB_FIRST_EN (see package) flips the emission order.
module bit_scan_serializer
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [IDXW:0]   out_seq,
    output logic            out_last
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [IDXW:0]    seq_q, seq_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            seq_q   <= seq_d;
        end
    end

    // Ending mask hands in_ready straight through so a new one loads without a bubble
    always_comb begin
        out_valid = (state_q == SCAN);
        out_idx   = IDXW'(pick_first(MAXW'(work_q), WIDTH));
        out_seq   = seq_q;
        out_last  = $onehot(work_q);
        in_ready  = !out_valid || (out_ready && out_last);
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        seq_d   = seq_q;
        accept  = in_valid && in_ready;
        unique case (state_q)
            IDLE: begin
                if (accept && |in_mask) begin
                    work_d  = in_mask;
                    seq_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (!out_last) begin
                        work_d = work_q & ~(WIDTH'(1) << out_idx);
                        seq_d  = seq_q + (IDXW+1)'(1);
                    end else if (accept && |in_mask) begin
                        work_d = in_mask;
                        seq_d  = '0;
                    end else begin
                        work_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Self-checking bench for bit_scan_serializer (WIDTH=8).
// Reference keeps a queue of outputs still owed for the current mask.
module tb_bit_scan_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_idx;
    logic [3:0]   out_seq;
    logic         out_last;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int seq;
        bit last;
    } item_t;

    item_t q[$];

    bit_scan_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_seq   (out_seq),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected output list: set positions in emission order, numbered from 0
    task automatic push_mask(input logic [W-1:0] m);
        int pos[$];
        item_t it;
        for (int i = 0; i < W; i++)
            if (m[i]) pos.push_back(i);
`ifdef BIT_SCAN_MSB_FIRST_EN
        pos.reverse();
`endif
        foreach (pos[k]) begin
            it.idx  = pos[k];
            it.seq  = k;
            it.last = (k == pos.size() - 1);
            q.push_back(it);
        end
    endtask

    task automatic cycle(input logic r, input logic iv,
                         input logic [W-1:0] m, input logic ordy);
        logic ev, er;
        rst       = r;
        in_valid  = iv;
        in_mask   = m;
        out_ready = ordy;
        #2;
        ev = (q.size() != 0);
        er = !ev || (ordy && q[0].last);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(er));
        if (ev) begin
            chk("out_idx", 32'(out_idx), 32'(q[0].idx));
            chk("out_seq", 32'(out_seq), 32'(q[0].seq));
            chk("out_last", 32'(out_last), 32'(q[0].last));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (ev && ordy) void'(q.pop_front());
            if (iv && er) push_mask(m);
        end
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idx"}, 32'(out_idx), 32'd0);
        chk({tag, "_seq"}, 32'(out_seq), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    initial begin
        logic [W-1:0] m;
        int sel;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");

        // Handshake during reset is ignored
        cycle(1, 1, 8'hA5, 1);
        chk_idle_zero("rst_hs");

        // Basic order
        cycle(0, 1, 8'b1010_0100, 1);
        repeat (4) cycle(0, 0, 8'h00, 1);

        // Zero mask
        cycle(0, 1, 8'h00, 1);
        repeat (2) cycle(0, 0, 8'h00, 1);

        // Backpressure
        cycle(0, 1, 8'h14, 0);
        repeat (3) cycle(0, 0, 8'h00, 0);
        repeat (3) cycle(0, 0, 8'h00, 1);

        // Back-to-back, no bubble
        cycle(0, 1, 8'h80, 1);
        cycle(0, 1, 8'h01, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);

        // All-ones, full count
        cycle(0, 1, 8'hFF, 1);
        repeat (9) cycle(0, 0, 8'h00, 1);

        // Mid-scan reset
        cycle(0, 1, 8'hFF, 1);
        repeat (3) cycle(0, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 1);
        chk_idle_zero("midrst");
        cycle(0, 1, 8'h02, 1);
        repeat (2) cycle(0, 0, 8'h00, 1);

        // Zero mask offered right at end of scan
        cycle(0, 1, 8'h03, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) m = '0;
            else if (sel == 1) m = '1;
            else m = W'($urandom);
            cycle(($urandom_range(0, 59) == 0), 1'($urandom),
                  m, ($urandom_range(0, 3) != 0));
        end
        repeat (12) cycle(0, 0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
